// File: rtl/serial_frame_pkg.sv
// Shared types and defaults for the serial frame receiver.
// rx_state_t FSM encoding, default frame geometry, idle line level.
package serial_frame_pkg;

  localparam int DEF_CLKS_PER_BIT = 16;
  localparam int DEF_DATA_BITS    = 8;
  localparam logic IDLE_LEVEL     = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    BREAK
  } rx_state_t;

endpackage

// File: rtl/serial_frame_rx_sync_2ff.sv
// sync_2ff: two-flop synchronizer for an asynchronous single-bit input.
// Ports: clk, rst_n (async, active low), d (async in), q (synced out).
module sync_2ff #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/serial_frame_rx.sv
// serial_frame_rx: start/data/stop serial receiver with valid/ready output.
// Ports: clk, rst_n, rx_in; rx_data/rx_valid/rx_ready handshake;
// frame_err, overrun pulses; busy. Option: SERIAL_FRAME_RX_PARITY_EN.
module serial_frame_rx
  import serial_frame_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
  parameter int DATA_BITS    = DEF_DATA_BITS
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx_in,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 busy
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int IW = $clog2(DATA_BITS + 1);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] LAST = IW'(DATA_BITS - 1);

  rx_state_t            state;
  logic                 ln;
  logic [CW-1:0]        cnt;
  logic [IW-1:0]        idx;
  logic [DATA_BITS-1:0] shreg;
  logic                 tick;
  logic                 par_ok;

  sync_2ff #(
    .RST_VAL(IDLE_LEVEL)
  ) u_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (rx_in),
    .q    (ln)
  );

  assign tick = (cnt == FULL);

`ifdef SERIAL_FRAME_RX_PARITY_EN
  logic par_bad;
  assign par_ok = !par_bad;
`else
  assign par_ok = 1'b1;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      idx       <= '0;
      shreg     <= '0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
      busy      <= 1'b0;
`ifdef SERIAL_FRAME_RX_PARITY_EN
      par_bad   <= 1'b0;
`endif
    end else begin
      frame_err <= 1'b0;
      overrun   <= 1'b0;
      cnt       <= cnt + CW'(1);
      if (rx_valid && rx_ready)
        rx_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (ln != IDLE_LEVEL) begin
            state <= START;
            busy  <= 1'b1;
            cnt   <= '0;
          end
        end
        START: begin
          // mid-start-bit check rejects short glitches
          if (cnt == HALF) begin
            cnt <= '0;
            idx <= '0;
            if (ln == IDLE_LEVEL) begin
              state <= IDLE;
              busy  <= 1'b0;
            end else begin
              state <= DATA;
            end
          end
        end
        DATA: begin
          if (tick) begin
            cnt   <= '0;
            idx   <= idx + IW'(1);
            shreg <= {ln, shreg[DATA_BITS-1:1]};
            if (idx == LAST) begin
`ifdef SERIAL_FRAME_RX_PARITY_EN
              state <= PARITY;
`else
              state <= STOP;
`endif
            end
          end
        end
`ifdef SERIAL_FRAME_RX_PARITY_EN
        PARITY: begin
          if (tick) begin
            cnt     <= '0;
            par_bad <= (^shreg) ^ ln;
            state   <= STOP;
          end
        end
`endif
        STOP: begin
          if (tick) begin
            cnt <= '0;
            if (ln != IDLE_LEVEL) begin
              frame_err <= 1'b1;
              state     <= BREAK;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
              if (!par_ok) begin
                frame_err <= 1'b1;
              end else if (rx_valid && !rx_ready) begin
                overrun <= 1'b1;
              end else begin
                rx_data  <= shreg;
                rx_valid <= 1'b1;
              end
            end
          end
        end
        BREAK: begin
          if (ln == IDLE_LEVEL) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_frame_rx.sv
// Directed + random bench for serial_frame_rx.
// Drives serial frames bit by bit and compares received bytes/pulses.
module tb_serial_frame_rx;

  localparam int CPB = 16;
`ifdef SERIAL_FRAME_RX_PARITY_EN
  localparam int LAT = 155 + CPB;
`else
  localparam int LAT = 155;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx_in = 1'b1;
  logic       rx_ready = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int t_start = 0;

  logic [7:0] got[$];
  int         got_cyc[$];
  int         n_vcyc = 0;
  int         n_ferr = 0;
  int         n_ovr = 0;
  logic       vprev = 1'b0;

  serial_frame_rx #(
    .CLKS_PER_BIT(CPB),
    .DATA_BITS   (8)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .rx_in    (rx_in),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_ready (rx_ready),
    .frame_err(frame_err),
    .overrun  (overrun),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // observer: logs each new byte presented and counts pulses
  always @(negedge clk) begin
    if (rx_valid && !vprev) begin
      got.push_back(rx_data);
      got_cyc.push_back(cyc);
    end
    if (rx_valid) n_vcyc <= n_vcyc + 1;
    if (frame_err) n_ferr <= n_ferr + 1;
    if (overrun) n_ovr <= n_ovr + 1;
    vprev <= rx_valid;
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive_bit(input logic b);
    rx_in = b;
    repeat (CPB) @(posedge clk);
    #1;
  endtask

  task automatic idle_bits(input int n);
    for (int i = 0; i < n; i++) drive_bit(1'b1);
  endtask

  // flip inverts the even-parity bit when the parity option is built in
  task automatic send_frame(input logic [7:0] d, input logic stop,
                            input logic flip);
    t_start = cyc;
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
`ifdef SERIAL_FRAME_RX_PARITY_EN
    drive_bit((^d) ^ flip);
`else
    if (flip) rx_in = 1'b1;
`endif
    drive_bit(stop);
  endtask

  function automatic logic [7:0] got_at(input int i);
    if (got.size() > i) return got[i];
    return 8'hxx;
  endfunction

  initial begin
    int b0, f0, o0, v0, lat, nr;
    logic [7:0] exp_q[$];
    logic [7:0] d;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_data", rx_data, 0);
    chk("rst_valid", rx_valid, 0);
    chk("rst_ferr", frame_err, 0);
    chk("rst_ovr", overrun, 0);
    chk("rst_busy", busy, 0);
    rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("idle_busy", busy, 0);

    // single byte, consumer always ready
    rx_ready = 1'b1;
    b0 = got.size();
    v0 = n_vcyc;
    f0 = n_ferr;
    send_frame(8'hA5, 1'b1, 1'b0);
    idle_bits(2);
    chk("a5_count", got.size() - b0, 1);
    chk("a5_data", got_at(b0), 8'hA5);
    lat = (got_cyc.size() > b0) ? got_cyc[b0] - t_start : -1;
    chk("a5_latency", lat, LAT);
    chk("a5_vcycles", n_vcyc - v0, 1);
    chk("a5_ferr", n_ferr - f0, 0);

    // random bytes with random idle gaps (including zero)
    b0 = got.size();
    nr = 6;
    for (int i = 0; i < nr; i++) begin
      d = 8'($urandom);
      exp_q.push_back(d);
      send_frame(d, 1'b1, 1'b0);
      idle_bits($urandom_range(0, 3));
    end
    idle_bits(1);
    chk("rnd_count", got.size() - b0, nr);
    for (int i = 0; i < nr; i++)
      chk($sformatf("rnd_data%0d", i), got_at(b0 + i), exp_q[i]);

    // back-to-back frames while consumer stalls
    rx_ready = 1'b0;
    b0 = got.size();
    o0 = n_ovr;
    send_frame(8'h3C, 1'b1, 1'b0);
    send_frame(8'hC3, 1'b1, 1'b0);
    idle_bits(1);
    chk("ovr_data", rx_data, 8'h3C);
    chk("ovr_valid", rx_valid, 1);
    chk("ovr_pulses", n_ovr - o0, 1);
    chk("ovr_count", got.size() - b0, 1);
    rx_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("accept_clear", rx_valid, 0);

    // stop bit low: framing error, line held low
    b0 = got.size();
    f0 = n_ferr;
    send_frame(8'h55, 1'b0, 1'b0);
    repeat (20) @(posedge clk);
    #1;
    chk("brk_busy", busy, 1);
    chk("brk_ferr", n_ferr - f0, 1);
    chk("brk_novalid", got.size() - b0, 0);
    rx_in = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("brk_release", busy, 0);

    // short low glitch while idle
    idle_bits(1);
    b0 = got.size();
    f0 = n_ferr;
    rx_in = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rx_in = 1'b1;
    repeat (30) @(posedge clk);
    #1;
    chk("gl_novalid", got.size() - b0, 0);
    chk("gl_noferr", n_ferr - f0, 0);
    chk("gl_busy", busy, 0);

    // reset in the middle of a 0xFF frame
    drive_bit(1'b0);
    drive_bit(1'b1);
    drive_bit(1'b1);
    chk("mid_busy", busy, 1);
    rst_n = 1'b0;
    #2;
    chk("mr_data", rx_data, 0);
    chk("mr_valid", rx_valid, 0);
    chk("mr_busy", busy, 0);
    chk("mr_ferr", frame_err, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle_bits(1);
    b0 = got.size();
    f0 = n_ferr;
    send_frame(8'h12, 1'b1, 1'b0);
    idle_bits(2);
    chk("mr_count", got.size() - b0, 1);
    chk("mr_new", got_at(b0), 8'h12);
    chk("mr_noferr", n_ferr - f0, 0);

`ifdef SERIAL_FRAME_RX_PARITY_EN
    b0 = got.size();
    f0 = n_ferr;
    send_frame(8'h07, 1'b1, 1'b1);
    idle_bits(1);
    chk("par_bad_ferr", n_ferr - f0, 1);
    chk("par_bad_drop", got.size() - b0, 0);
    send_frame(8'h07, 1'b1, 1'b0);
    idle_bits(1);
    chk("par_ok_count", got.size() - b0, 1);
    chk("par_ok_data", got_at(b0), 8'h07);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
